// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, issues one word fetch at a time, delivers (pc, instr) to IF/ID.
// Latency: a request accepted in cycle N with its response in cycle M delivers in cycle M+1 (one instruction per 2 cycles with a zero-wait imem).
// Backpressure: imem_req_ready low holds the request and the PC; stall_in withholds issue and parks one response in a hold buffer.
// Optional feature: define FETCH_MISALIGN_CHK_EN to add fetch_misalign_out, which flags redirect targets with nonzero bits [1:0].
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] PC_line_out,
  output logic [31:0] instruct_data_line_out,
  output logic        inst_valid_out,
  output logic        if_flush_out
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        fetch_misalign_out
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] req_pc_q, req_pc_n;
  logic        drop_q, drop_n;
  logic [31:0] hold_pc_q, hold_pc_n;
  logic [31:0] hold_dat_q, hold_dat_n;

  logic        dlv;
  logic [31:0] dlv_pc;
  logic [31:0] dlv_dat;
  logic        req_fire;
  logic [31:0] redir_tgt;

  // The request is combinational so a stall withdraws it in the same cycle.
  assign imem_req_valid = !rst && (state_q == S_REQ) && !stall_in;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // Fetches are word-granular; the low two target bits never reach the PC.
  assign redir_tgt      = redirect_pc & ~32'h0000_0003;

  // Next-state, PC and delivery selection; a redirect overrides stall and response handling.
  always_comb begin
    state_n    = state_q;
    pc_n       = pc_q;
    req_pc_n   = req_pc_q;
    drop_n     = drop_q;
    hold_pc_n  = hold_pc_q;
    hold_dat_n = hold_dat_q;
    dlv        = 1'b0;
    dlv_pc     = req_pc_q;
    dlv_dat    = imem_rsp_data;

    if (redirect_valid) begin
      pc_n = redir_tgt;
      case (state_q)
        S_REQ: begin
          // A request accepted alongside the redirect is already stale.
          if (req_fire) begin
            state_n = S_WAIT;
            drop_n  = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            state_n = S_REQ;
            drop_n  = 1'b0;
          end else begin
            drop_n  = 1'b1;
          end
        end
        S_HOLD: begin
          state_n = S_REQ;
        end
        default: begin
          state_n = S_REQ;
        end
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            pc_n     = pc_q + 32'd4;
            req_pc_n = pc_q;
            state_n  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop_q) begin
              drop_n  = 1'b0;
              state_n = S_REQ;
            end else if (!stall_in) begin
              dlv     = 1'b1;
              state_n = S_REQ;
            end else begin
              hold_pc_n  = req_pc_q;
              hold_dat_n = imem_rsp_data;
              state_n    = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall_in) begin
            dlv     = 1'b1;
            dlv_pc  = hold_pc_q;
            dlv_dat = hold_dat_q;
            state_n = S_REQ;
          end
        end
        default: begin
          state_n = S_REQ;
        end
      endcase
    end
  end

  // Fetch control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'h0;
      drop_q     <= 1'b0;
      hold_pc_q  <= 32'h0;
      hold_dat_q <= NOP_INSTR;
    end else begin
      state_q    <= state_n;
      pc_q       <= pc_n;
      req_pc_q   <= req_pc_n;
      drop_q     <= drop_n;
      hold_pc_q  <= hold_pc_n;
      hold_dat_q <= hold_dat_n;
    end
  end

  // Registered delivery toward IF/ID; PC/instruction hold between deliveries.
  always_ff @(posedge clk) begin
    if (rst) begin
      PC_line_out            <= 32'h0;
      instruct_data_line_out <= NOP_INSTR;
      inst_valid_out         <= 1'b0;
      if_flush_out           <= 1'b0;
    end else begin
      inst_valid_out <= dlv;
      if_flush_out   <= redirect_valid;
      if (dlv) begin
        PC_line_out            <= dlv_pc;
        instruct_data_line_out <= dlv_dat;
      end
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  // One-cycle misalignment flag, aligned with the flush pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_misalign_out <= 1'b0;
    end else begin
      fetch_misalign_out <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: sequential fetch, imem backpressure, stall hold, redirects, PC wrap.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
// The imem model answers one cycle after accept unless rsp_en holds the response back.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] PC_line_out;
  logic [31:0] instruct_data_line_out;
  logic        inst_valid_out;
  logic        if_flush_out;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        fetch_misalign_out;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic        rsp_en;
  logic        pend;
  logic [31:0] pend_addr;
  logic        acc;
  logic [31:0] acc_addr;

  if_fetch dut (
    .clk                    (clk),
    .rst                    (rst),
    .stall_in               (stall_in),
    .redirect_valid         (redirect_valid),
    .redirect_pc            (redirect_pc),
    .imem_req_valid         (imem_req_valid),
    .imem_req_addr          (imem_req_addr),
    .imem_req_ready         (imem_req_ready),
    .imem_rsp_valid         (imem_rsp_valid),
    .imem_rsp_data          (imem_rsp_data),
    .PC_line_out            (PC_line_out),
    .instruct_data_line_out (instruct_data_line_out),
    .inst_valid_out         (inst_valid_out),
    .if_flush_out           (if_flush_out)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .fetch_misalign_out     (fetch_misalign_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: word(a) = 0x0050_008F + a, so word(4) = 0x0050_0093 (addi x1,x0,5).
  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h0050_008F + a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: samples the handshake mid-cycle, answers in the cycle after accept.
  initial begin
    pend           = 1'b0;
    pend_addr      = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      acc      = imem_req_valid && imem_req_ready && !rst;
      acc_addr = imem_req_addr;
      @(posedge clk);
      #2;
      imem_rsp_valid = 1'b0;
      if (rst) pend = 1'b0;
      if (acc) begin
        pend      = 1'b1;
        pend_addr = acc_addr;
      end
      if (pend && rsp_en) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word(pend_addr);
        pend           = 1'b0;
      end
    end
  end

  initial begin
    rst            = 1'b1;
    stall_in       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    rsp_en         = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc",    PC_line_out, 32'h0);
    chk("rst_instr", instruct_data_line_out, 32'h0000_0013);
    chk("rst_valid", {31'b0, inst_valid_out}, 32'h0);
    chk("rst_flush", {31'b0, if_flush_out}, 32'h0);
    chk("rst_req",   {31'b0, imem_req_valid}, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("rst_misalign", {31'b0, fetch_misalign_out}, 32'h0);
`endif

    // C1: first request at RESET_PC
    to_pos(); rst = 1'b0;
    @(negedge clk);
    chk("c1_req", {31'b0, imem_req_valid}, 32'h1);
    chk("c1_addr", imem_req_addr, 32'h0);
    // C2: waiting on response
    to_pos();
    @(negedge clk);
    chk("c2_req", {31'b0, imem_req_valid}, 32'h0);
    chk("c2_valid", {31'b0, inst_valid_out}, 32'h0);
    // C3: pc 0 delivered, next request at 4
    to_pos();
    @(negedge clk);
    chk("c3_valid", {31'b0, inst_valid_out}, 32'h1);
    chk("c3_pc", PC_line_out, 32'h0);
    chk("c3_instr", instruct_data_line_out, 32'h0050_008F);
    chk("c3_addr", imem_req_addr, 32'h4);
    // C4
    to_pos();
    @(negedge clk);
    chk("c4_valid", {31'b0, inst_valid_out}, 32'h0);
    // C5: pc 4 delivered; imem stops accepting with addr 8 pending
    to_pos(); imem_req_ready = 1'b0;
    @(negedge clk);
    chk("c5_valid", {31'b0, inst_valid_out}, 32'h1);
    chk("c5_pc", PC_line_out, 32'h4);
    chk("c5_instr", instruct_data_line_out, 32'h0050_0093);
    chk("c5_addr", imem_req_addr, 32'h8);
    // C6-C7: request holds at 8
    for (int i = 0; i < 2; i++) begin
      to_pos();
      @(negedge clk);
      chk("bp_req", {31'b0, imem_req_valid}, 32'h1);
      chk("bp_addr", imem_req_addr, 32'h8);
      chk("bp_valid", {31'b0, inst_valid_out}, 32'h0);
    end
    // C8: imem ready again
    to_pos(); imem_req_ready = 1'b1;
    @(negedge clk);
    chk("c8_addr", imem_req_addr, 32'h8);
    // C9-C12: stall while the pc 8 response arrives
    for (int i = 0; i < 4; i++) begin
      to_pos(); stall_in = 1'b1;
      @(negedge clk);
      chk("stall_valid", {31'b0, inst_valid_out}, 32'h0);
      chk("stall_req", {31'b0, imem_req_valid}, 32'h0);
    end
    // C13: release, hold buffer delivers at the edge
    to_pos(); stall_in = 1'b0;
    @(negedge clk);
    chk("c13_valid", {31'b0, inst_valid_out}, 32'h0);
    chk("c13_req", {31'b0, imem_req_valid}, 32'h0);
    // C14: held instruction appears; imem will sit on the next response
    to_pos(); rsp_en = 1'b0;
    @(negedge clk);
    chk("c14_valid", {31'b0, inst_valid_out}, 32'h1);
    chk("c14_pc", PC_line_out, 32'h8);
    chk("c14_instr", instruct_data_line_out, 32'h0050_0097);
    chk("c14_addr", imem_req_addr, 32'hC);
    // C15: redirect while waiting on pc 12
    to_pos(); redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    chk("c15_valid", {31'b0, inst_valid_out}, 32'h0);
    chk("c15_flush", {31'b0, if_flush_out}, 32'h0);
    // C16: flush pulse, stale response arrives and is dropped
    to_pos(); redirect_valid = 1'b0; rsp_en = 1'b1;
    @(negedge clk);
    chk("c16_flush", {31'b0, if_flush_out}, 32'h1);
    chk("c16_valid", {31'b0, inst_valid_out}, 32'h0);
    chk("c16_req", {31'b0, imem_req_valid}, 32'h0);
    // C17: fetch at redirect target
    to_pos();
    @(negedge clk);
    chk("c17_flush", {31'b0, if_flush_out}, 32'h0);
    chk("c17_addr", imem_req_addr, 32'h100);
    chk("c17_req", {31'b0, imem_req_valid}, 32'h1);
    // C18
    to_pos();
    @(negedge clk);
    chk("c18_valid", {31'b0, inst_valid_out}, 32'h0);
    // C19: target delivered
    to_pos();
    @(negedge clk);
    chk("c19_valid", {31'b0, inst_valid_out}, 32'h1);
    chk("c19_pc", PC_line_out, 32'h100);
    chk("c19_instr", instruct_data_line_out, 32'h0050_018F);
    chk("c19_addr", imem_req_addr, 32'h104);
    // C20: redirect + stall coincide with the pc 0x104 response
    to_pos(); stall_in = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    chk("c20_valid", {31'b0, inst_valid_out}, 32'h0);
    // C21
    to_pos(); stall_in = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    chk("c21_flush", {31'b0, if_flush_out}, 32'h1);
    chk("c21_valid", {31'b0, inst_valid_out}, 32'h0);
    chk("c21_addr", imem_req_addr, 32'h200);
    chk("c21_req", {31'b0, imem_req_valid}, 32'h1);
    // C22
    to_pos();
    @(negedge clk);
    chk("c22_valid", {31'b0, inst_valid_out}, 32'h0);
    // C23: 0x200 delivered, nothing from 0x104 leaked through
    to_pos();
    @(negedge clk);
    chk("c23_valid", {31'b0, inst_valid_out}, 32'h1);
    chk("c23_pc", PC_line_out, 32'h200);
    chk("c23_instr", instruct_data_line_out, 32'h0050_028F);
    // C24: misaligned redirect target
    to_pos(); redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    chk("c24_flush", {31'b0, if_flush_out}, 32'h0);
    // C25
    to_pos(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("c25_flush", {31'b0, if_flush_out}, 32'h1);
    chk("c25_addr", imem_req_addr, 32'h100);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("c25_misalign", {31'b0, fetch_misalign_out}, 32'h1);
`endif
    // C26: redirect to the top word to exercise PC wrap
    to_pos(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("c26_misalign", {31'b0, fetch_misalign_out}, 32'h0);
`endif
    chk("c26_flush", {31'b0, if_flush_out}, 32'h0);
    // C27
    to_pos(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("c27_addr", imem_req_addr, 32'hFFFF_FFFC);
    // C28
    to_pos();
    @(negedge clk);
    chk("c28_valid", {31'b0, inst_valid_out}, 32'h0);
    // C29: top word delivered, PC wrapped to 0
    to_pos();
    @(negedge clk);
    chk("c29_valid", {31'b0, inst_valid_out}, 32'h1);
    chk("c29_pc", PC_line_out, 32'hFFFF_FFFC);
    chk("c29_instr", instruct_data_line_out, 32'h0050_008B);
    chk("c29_addr", imem_req_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
